booth_seq_mul: RTL and testbench



---
 rtl/booth_seq_mul.sv | 172 +++++++++++++++++
 tb/tb_booth_seq_mul.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_mul.sv
// ---------------------------------------------------------------------------
// booth_seq_mul
//
// Sequential radix-2 Booth multiplier. One multiplier bit is retired per
// clock through a single (WIDTH+1)-bit adder/subtractor, so the datapath cost
// stays flat as WIDTH grows. Both operands are extended by one bit (sign- or
// zero-extension, selected per operation), which makes the same Booth
// recoding exact for signed and unsigned operands alike.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over everything)
//   in_valid   operand pair and mode are valid
//   in_ready   block can accept an operation (high only while idle)
//   in1        multiplicand, WIDTH bits
//   in2        multiplier, WIDTH bits
//   sign_mode  1 = both operands two's complement, 0 = both unsigned
//   out_valid  product valid (high only while holding a result)
//   out_ready  consumer takes the product this cycle
//   out        product, 2*WIDTH bits, stable while out_valid is high
//
// Timing
//   Acceptance edge E0, Booth steps at E1..E(WIDTH+1), out_valid high from
//   just after E(WIDTH+1). Minimum initiation interval is WIDTH+3 cycles.
// ---------------------------------------------------------------------------
module booth_seq_mul #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic                 sign_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    // Extended operand width and accumulator width (2*W1 product + pseudo bit).
    localparam int W1 = WIDTH + 1;
    localparam int AW = 2 * W1 + 1;
    localparam int CW = $clog2(WIDTH + 1);

    // Step counter value during the final (W1-th) Booth step.
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Registered state.
    logic [1:0]          state_r;
    logic [W1-1:0]       mcand_r;
    logic [AW-1:0]       acc_r;
    logic [CW-1:0]       cnt_r;
    logic [2*WIDTH-1:0]  out_r;
    logic                out_valid_r;
    logic                in_ready_r;

    // Next-state values.
    logic [1:0]          state_s;
    logic [W1-1:0]       mcand_s;
    logic [AW-1:0]       acc_s;
    logic [CW-1:0]       cnt_s;
    logic [2*WIDTH-1:0]  out_s;
    logic                out_valid_s;
    logic                in_ready_s;

    // Booth step datapath.
    logic [W1-1:0]       upper_s;
    logic [W1-1:0]       sum_s;
    logic [AW-1:0]       step_s;

    // Extend an operand by one bit: sign bit replicated only in signed mode.
    function automatic logic [W1-1:0] extend_op(input logic [WIDTH-1:0] v,
                                                input logic             sgn);
        extend_op = {sgn & v[WIDTH-1], v};
    endfunction

    // One Booth step: add/sub the multiplicand to the upper half, then shift.
    always_comb begin
        upper_s = acc_r[AW-1 -: W1];
        sum_s   = upper_s;
        case (acc_r[1:0])
            2'b01:   sum_s = upper_s + mcand_r;
            2'b10:   sum_s = upper_s - mcand_r;
            default: sum_s = upper_s;
        endcase
        // Arithmetic right shift; the MSB comes from the post-add/sub value so
        // the (modulo 2^W1) wrap of the adder never corrupts the sign.
        step_s = {sum_s[W1-1], sum_s, acc_r[W1:1]};
    end

    // Sequencer: next-state and next-output computation.
    always_comb begin
        state_s     = state_r;
        mcand_s     = mcand_r;
        acc_s       = acc_r;
        cnt_s       = cnt_r;
        out_s       = out_r;
        out_valid_s = out_valid_r;
        in_ready_s  = in_ready_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    mcand_s    = extend_op(in1, sign_mode);
                    acc_s      = {{W1{1'b0}}, extend_op(in2, sign_mode), 1'b0};
                    cnt_s      = {CW{1'b0}};
                    in_ready_s = 1'b0;
                    state_s    = ST_RUN;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_s = step_s;
                if (cnt_r == LAST_STEP) begin
                    // Low 2*WIDTH bits of the 2*W1 product, pseudo bit dropped.
                    out_s       = step_s[2*WIDTH:1];
                    out_valid_s = 1'b1;
                    state_s     = ST_DONE;
                end else begin
                    cnt_s       = cnt_r + CW'(1);
                    state_s     = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s     = ST_DONE;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state.
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mcand_r     <= {W1{1'b0}};
            acc_r       <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            out_r       <= {(2*WIDTH){1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_s;
            mcand_r     <= mcand_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;

endmodule

// File: tb/tb_booth_seq_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_mul
//
// Scoreboard bench for booth_seq_mul (WIDTH=6). The driver pushes the ideal
// product and the acceptance cycle into a queue at each accepted operation;
// an independent monitor compares every presented result, its stability
// under backpressure and its latency.
// ---------------------------------------------------------------------------
module tb_booth_seq_mul;

    localparam int W  = 6;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic          sign_mode;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out;

    typedef struct {
        logic [PW-1:0] prod;
        int            acc_cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rdy_rand = 1'b0;

    booth_seq_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .sign_mode (sign_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ideal product from plain integer arithmetic, truncated to 2*W bits.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic m);
        longint x, y, p;
        x = m ? longint'($signed(a)) : longint'(a);
        y = m ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[PW-1:0];
    endfunction

    // Present one operation and wait (bounded) until it is accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [PW-1:0] e);
        int n = 0;
        bit done = 1'b0;
        exp_t item;
        in1 = a; in2 = b; sign_mode = m; in_valid = 1'b1;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (in_ready && !rst) begin
                item.prod = e;
                item.acc_cyc = cyc + 1;
                q.push_back(item);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance within 300 cycles");
        end
        @(posedge clk);
        #1;
        // Scramble inputs: only the acceptance edge may matter.
        in_valid  = 1'b0;
        in1       = W'($urandom);
        in2       = W'($urandom);
        sign_mode = 1'($urandom);
    endtask

    // Wait (bounded) until every expected result has been consumed.
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Random consumer backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare every presented result against the scoreboard head.
    initial begin
        bit prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready && out_valid) begin
                checks++; errors++;
                $display("FAIL ready_valid_exclusive: got both high expected at most one");
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got out=%0h expected no result", out);
                end else begin
                    chk("product", 64'(out), 64'(q[0].prod));
                    if (!prev_valid) chk("latency", 64'(cyc - q[0].acc_cyc), 64'(W + 1));
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        logic [W-1:0] a, b;
        logic         m;
        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; sign_mode = 1'b0; out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed products.
        issue(6'h20, 6'h20, 1'b1, 12'h400);
        issue(6'h1F, 6'h20, 1'b1, 12'hC20);
        issue(6'h3F, 6'h01, 1'b1, 12'hFFF);
        issue(6'h3F, 6'h3F, 1'b0, 12'hF81);
        issue(6'h3F, 6'h3F, 1'b1, 12'h001);
        issue(6'h20, 6'h20, 1'b0, 12'h400);
        drain();

        // Backpressure: result held, new requests ignored.
        out_ready = 1'b0;
        issue(6'h0B, 6'h2D, 1'b0, 12'h1EF);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin @(negedge clk); n++; end
            chk("bp_valid_seen", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1; in1 = 6'h11; in2 = 6'h22; sign_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_valid_held", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("bp_no_queued_op", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a run: operation discarded.
        issue(6'h15, 6'h0A, 1'b1, 12'h0D2);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out", 64'(out), 64'd0);
        @(posedge clk);
        #1;
        issue(6'h05, 6'h3D, 1'b1, 12'hFF1);
        drain();

        // Randomised operations with gaps and random backpressure.
        rdy_rand = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            case ($urandom_range(0, 7))
                0:       a = 6'h20;
                1:       a = 6'h1F;
                2:       a = 6'h3F;
                3:       a = 6'h00;
                default: a = W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = 6'h20;
                1:       b = 6'h1F;
                2:       b = 6'h3F;
                3:       b = 6'h01;
                default: b = W'($urandom);
            endcase
            m = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            issue(a, b, m, ref_mul(a, b, m));
        end
        drain();
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
